// File: rtl/cory_resp_route8_pkg.sv
// Shared definitions for the cory response-router family: source-id width,
// port count and a constant clog2 helper used to size pointers and counters.
package cory_resp_route8_pkg;

    localparam int CORY_SRC_W = 3;
    localparam int CORY_PORTS = 8;

    function automatic int cory_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cory_resp_route8_tagq.sv
// cory_tagq: small tag FIFO remembering the source id of every forwarded
// request so that in-order responses can be steered back to their origin.
// Pointers carry one extra bit and wrap naturally; occupancy is tracked in a
// separate counter so full/empty never rely on pointer comparison.
// The caller guarantees push is never asserted while full and pop is never
// asserted while empty.
module cory_tagq
    import cory_resp_route8_pkg::*;
#(
    parameter int W  = CORY_SRC_W,
    parameter int D  = 8,
    localparam int AW = cory_clog2(D)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   cnt
);

    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [W-1:0] mem_q [D];
    logic [W-1:0] mem_d [D];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [AW:0]  cnt_q, cnt_d;

    // Next-state for storage, both pointers and the occupancy counter.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d = wptr_q + ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + ONE;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + ONE;
            2'b01:   cnt_d = cnt_q - ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers and count reset to empty; tag storage needs no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Tag storage update.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign cnt   = cnt_q;

endmodule

// File: rtl/cory_resp_route8.sv
// cory_resp_route8: order-tracking response router behind the 8:1 arbiter.
// Requests pass straight to the single target while their source ids are
// queued; each in-order response is steered to the port at the queue head.
// Optional macro CORY_RESP_ROUTE8_ERR_EN enables a sticky o_err flag for
// unsolicited responses (and an internal push-while-full check).
module cory_resp_route8
    import cory_resp_route8_pkg::*;
#(
    parameter int N  = 8,
    parameter int D  = 8,
    localparam int AW = cory_clog2(D)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_a_v,
    input  logic [N-1:0]          i_a_d,
    input  logic [CORY_SRC_W-1:0] i_a_s,
    output logic                  o_a_r,
    output logic                  o_b_v,
    output logic [N-1:0]          o_b_d,
    input  logic                  i_b_r,
    input  logic                  i_c_v,
    input  logic [N-1:0]          i_c_d,
    output logic                  o_c_r,
    output logic [CORY_PORTS-1:0] o_z_v,
    output logic [N-1:0]          o_z_d,
    input  logic [CORY_PORTS-1:0] i_z_r,
    output logic [AW:0]           o_cnt,
    output logic                  o_err
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(D);

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [CORY_SRC_W-1:0] head;
    logic [AW:0]           cnt;

    cory_tagq #(
        .W (CORY_SRC_W),
        .D (D)
    ) u_tagq (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (i_a_s),
        .rdata (head),
        .cnt   (cnt)
    );

    // Handshake gating on both paths plus the head-tag 3->8 decode; readies
    // depend only on occupancy and the far side's ready, never on own valid.
    always_comb begin
        full  = (cnt == DEPTH_CNT);
        empty = (cnt == '0);
        o_b_v = i_a_v & ~full;
        o_a_r = i_b_r & ~full;
        push  = i_a_v & o_a_r;
        o_c_r = ~empty & i_z_r[head];
        pop   = i_c_v & o_c_r;
        o_z_v = '0;
        if (i_c_v & ~empty) begin
            o_z_v[head] = 1'b1;
        end
    end

    assign o_b_d = i_a_d;
    assign o_z_d = i_c_d;
    assign o_cnt = cnt;

`ifdef CORY_RESP_ROUTE8_ERR_EN
    logic err_q, err_d;

    // Sticky error: a response arriving with nothing outstanding, or a push
    // into a full queue, latches until reset.
    always_comb begin
        err_d = err_q | (i_c_v & empty) | (push & full);
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_cory_resp_route8.sv
// Testbench for cory_resp_route8: directed scenarios with hand-computed
// expectations plus a negedge monitor that keeps a queue of outstanding
// source ids and checks routing, readies and count on every cycle.
module tb_cory_resp_route8;

    localparam int N = 8;
    localparam int D = 8;

`ifdef CORY_RESP_ROUTE8_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_a_v = 1'b0;
    logic [N-1:0] i_a_d = '0;
    logic [2:0]   i_a_s = '0;
    logic         o_a_r;
    logic         o_b_v;
    logic [N-1:0] o_b_d;
    logic         i_b_r = 1'b1;
    logic         i_c_v = 1'b0;
    logic [N-1:0] i_c_d = '0;
    logic         o_c_r;
    logic [7:0]   o_z_v;
    logic [N-1:0] o_z_d;
    logic [7:0]   i_z_r = 8'hFF;
    logic [3:0]   o_cnt;
    logic         o_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] tag_sb[$];

    cory_resp_route8 #(.N(N), .D(D)) dut (
        .clk   (clk),
        .reset (reset),
        .i_a_v (i_a_v),
        .i_a_d (i_a_d),
        .i_a_s (i_a_s),
        .o_a_r (o_a_r),
        .o_b_v (o_b_v),
        .o_b_d (o_b_d),
        .i_b_r (i_b_r),
        .i_c_v (i_c_v),
        .i_c_d (i_c_d),
        .o_c_r (o_c_r),
        .o_z_v (o_z_v),
        .o_z_d (o_z_d),
        .i_z_r (i_z_r),
        .o_cnt (o_cnt),
        .o_err (o_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic a_v, input logic [2:0] a_s, input logic b_r,
                                 input logic c_v, input logic [7:0] c_d, input logic [7:0] z_r);
        @(posedge clk);
        #1;
        i_a_v = a_v;
        i_a_s = a_s;
        i_a_d = {5'h15, a_s};
        i_b_r = b_r;
        i_c_v = c_v;
        i_c_d = c_d;
        i_z_r = z_r;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 8'hFF);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        i_a_v = 1'b0;
        i_c_v = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: checks every output against the outstanding-tag queue, then
    // applies the handshakes that the coming rising edge will perform.
    always @(negedge clk) begin
        logic [2:0] h;
        logic       sb_full;
        logic       sb_empty;
        logic       exp_c_r;
        logic [7:0] exp_z_v;
        if (reset) begin
            tag_sb.delete();
        end else begin
            sb_full  = (tag_sb.size() == D);
            sb_empty = (tag_sb.size() == 0);
            h        = sb_empty ? 3'd0 : tag_sb[0];
            exp_c_r  = !sb_empty && i_z_r[h];
            exp_z_v  = (i_c_v && !sb_empty) ? (8'h01 << h) : 8'h00;
            checkOutput("mon_cnt", 32'(o_cnt), 32'(tag_sb.size()));
            checkOutput("mon_a_r", 32'(o_a_r), 32'(i_b_r && !sb_full));
            checkOutput("mon_b_v", 32'(o_b_v), 32'(i_a_v && !sb_full));
            checkOutput("mon_c_r", 32'(o_c_r), 32'(exp_c_r));
            checkOutput("mon_z_v", 32'(o_z_v), 32'(exp_z_v));
            if (exp_z_v != 8'h00) begin
                checkOutput("mon_z_d", 32'(o_z_d), 32'(i_c_d));
            end
            if (i_c_v && exp_c_r) begin
                void'(tag_sb.pop_front());
            end
            if (i_a_v && i_b_r && !sb_full) begin
                tag_sb.push_back(i_a_s);
            end
        end
    end

    initial begin
        $display("[TB] cory_resp_route8 test start");
        doReset();

        // Reset state
        @(negedge clk);
        checkOutput("rst_cnt", 32'(o_cnt), 32'd0);
        checkOutput("rst_z_v", 32'(o_z_v), 32'h00);
        checkOutput("rst_c_r", 32'(o_c_r), 32'd0);
        checkOutput("rst_a_r", 32'(o_a_r), 32'd1);
        checkOutput("rst_err", 32'(o_err), 32'd0);

        // 1: single request from source 5
        applyStimulus(1'b1, 3'd5, 1'b1, 1'b0, 8'h00, 8'hFF);
        @(negedge clk);
        checkOutput("t1_b_v", 32'(o_b_v), 32'd1);
        checkOutput("t1_b_d", 32'(o_b_d), 32'hAD);
        idleCycle();
        @(negedge clk);
        checkOutput("t1_cnt", 32'(o_cnt), 32'd1);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 8'h55, 8'hFF);
        @(negedge clk);
        checkOutput("t1_z_v", 32'(o_z_v), 32'h20);
        idleCycle();
        @(negedge clk);
        checkOutput("t1_cnt0", 32'(o_cnt), 32'd0);

        // 2: sources 2,7,0 then responses A1,A2,A3
        applyStimulus(1'b1, 3'd2, 1'b1, 1'b0, 8'h00, 8'hFF);
        applyStimulus(1'b1, 3'd7, 1'b1, 1'b0, 8'h00, 8'hFF);
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 8'h00, 8'hFF);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 8'hA1, 8'hFF);
        @(negedge clk);
        checkOutput("t2_z_v0", 32'(o_z_v), 32'h04);
        checkOutput("t2_z_d0", 32'(o_z_d), 32'hA1);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 8'hA2, 8'hFF);
        @(negedge clk);
        checkOutput("t2_z_v1", 32'(o_z_v), 32'h80);
        checkOutput("t2_z_d1", 32'(o_z_d), 32'hA2);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 8'hA3, 8'hFF);
        @(negedge clk);
        checkOutput("t2_z_v2", 32'(o_z_v), 32'h01);
        checkOutput("t2_z_d2", 32'(o_z_d), 32'hA3);
        idleCycle();
        @(negedge clk);
        checkOutput("t2_cnt0", 32'(o_cnt), 32'd0);

        // 3: fill to D, then pop with a pending push
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b1, 3'(i), 1'b1, 1'b0, 8'h00, 8'hFF);
        end
        applyStimulus(1'b1, 3'd6, 1'b1, 1'b0, 8'h00, 8'hFF);
        @(negedge clk);
        checkOutput("t3_cnt_full", 32'(o_cnt), 32'd8);
        checkOutput("t3_a_r_full", 32'(o_a_r), 32'd0);
        checkOutput("t3_b_v_full", 32'(o_b_v), 32'd0);
        applyStimulus(1'b1, 3'd6, 1'b1, 1'b1, 8'h30, 8'hFF);
        @(negedge clk);
        checkOutput("t3_pop_c_r", 32'(o_c_r), 32'd1);
        checkOutput("t3_pop_a_r", 32'(o_a_r), 32'd0);
        checkOutput("t3_pop_z_v", 32'(o_z_v), 32'h01);
        applyStimulus(1'b1, 3'd6, 1'b1, 1'b0, 8'h00, 8'hFF);
        @(negedge clk);
        checkOutput("t3_cnt7", 32'(o_cnt), 32'd7);
        checkOutput("t3_a_r7", 32'(o_a_r), 32'd1);
        idleCycle();
        @(negedge clk);
        checkOutput("t3_cnt_refill", 32'(o_cnt), 32'd8);
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 8'(8'h40 + i), 8'hFF);
            @(negedge clk);
            checkOutput("t3_drain_z_v", 32'(o_z_v), (i < 7) ? (32'h1 << (i + 1)) : 32'h40);
        end
        idleCycle();
        @(negedge clk);
        checkOutput("t3_cnt0", 32'(o_cnt), 32'd0);

        // 4: head tag 4 with port 4 stalled
        applyStimulus(1'b1, 3'd4, 1'b1, 1'b0, 8'h00, 8'hFF);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 8'hC4, 8'hEF);
        @(negedge clk);
        checkOutput("t4_c_r_stall", 32'(o_c_r), 32'd0);
        checkOutput("t4_z_v_stall", 32'(o_z_v), 32'h10);
        checkOutput("t4_z_d_stall", 32'(o_z_d), 32'hC4);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 8'hC4, 8'hEF);
        @(negedge clk);
        checkOutput("t4_cnt_held", 32'(o_cnt), 32'd1);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 8'hC4, 8'hFF);
        @(negedge clk);
        checkOutput("t4_c_r_go", 32'(o_c_r), 32'd1);
        idleCycle();
        @(negedge clk);
        checkOutput("t4_cnt0", 32'(o_cnt), 32'd0);

        // 5: unsolicited response while empty
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 8'h77, 8'hFF);
        @(negedge clk);
        checkOutput("t5_c_r", 32'(o_c_r), 32'd0);
        checkOutput("t5_z_v", 32'(o_z_v), 32'h00);
        idleCycle();
        @(negedge clk);
        checkOutput("t5_err", 32'(o_err), 32'(EXP_ERR));
        idleCycle();
        idleCycle();
        @(negedge clk);
        checkOutput("t5_err_sticky", 32'(o_err), 32'(EXP_ERR));
        doReset();
        @(negedge clk);
        checkOutput("t5_err_clr", 32'(o_err), 32'd0);
        checkOutput("t5_cnt_clr", 32'(o_cnt), 32'd0);

        // 6: random valid/ready back-pressure, monitor checks every cycle
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          8'($urandom), 8'($urandom | $urandom));
        end
        idleCycle();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
